// File: rtl/target_bbox_tracker.sv
// -----------------------------------------------------------------------------
// target_bbox_tracker
//
// Measures the bounding box of foreground (binarised) pixels over each video
// frame, commits a padded and clamped box when frame_sync closes the frame,
// and draws a ring-shaped overlay strobe around the committed box. When the
// target is lost the last box is kept on screen for a bounded number of
// frames (COAST) before the tracker falls back to ACQUIRE.
//
// Ports
//   clk_24m      in   system clock
//   rst_n        in   asynchronous active-low reset
//   pix_valid    in   hcnt/vcnt/fg qualify this cycle
//   fg           in   foreground pixel flag
//   hcnt, vcnt   in   pixel coordinates (CNT_W bits)
//   frame_sync   in   one-cycle pulse closing the current frame
//   box_on       out  overlay strobe for the pixel sampled one cycle earlier
//   bbox_valid   out  committed box is displayable (TRACK or COAST)
//   bbox_x0/x1   out  committed horizontal extent, inclusive
//   bbox_y0/y1   out  committed vertical extent, inclusive
//   pix_count    out  foreground count of the last closed frame
//   coasting     out  tracker is coasting on a stale box
// -----------------------------------------------------------------------------
module target_bbox_tracker #(
   parameter int CNT_W       = 11,
   parameter int H_MIN       = 154,
   parameter int H_MAX       = 784,
   parameter int V_MIN       = 35,
   parameter int V_MAX       = 515,
   parameter int PAD         = 4,
   parameter int BOX_T       = 3,
   parameter int MIN_PIX     = 16,
   parameter int HOLD_FRAMES = 8,
   parameter int COUNT_W     = 16
) (
   input  logic               clk_24m,
   input  logic               rst_n,
   input  logic               pix_valid,
   input  logic               fg,
   input  logic [CNT_W-1:0]   hcnt,
   input  logic [CNT_W-1:0]   vcnt,
   input  logic               frame_sync,
   output logic               box_on,
   output logic               bbox_valid,
   output logic [CNT_W-1:0]   bbox_x0,
   output logic [CNT_W-1:0]   bbox_x1,
   output logic [CNT_W-1:0]   bbox_y0,
   output logic [CNT_W-1:0]   bbox_y1,
   output logic [COUNT_W-1:0] pix_count,
   output logic               coasting
);

   // Extended width so that subtraction below zero and addition past the
   // counter range are both visible instead of wrapping.
   localparam int EW = CNT_W + 1;

   localparam logic [CNT_W-1:0]   H_MIN_C   = CNT_W'(H_MIN);
   localparam logic [CNT_W-1:0]   H_MAX_C   = CNT_W'(H_MAX);
   localparam logic [CNT_W-1:0]   V_MIN_C   = CNT_W'(V_MIN);
   localparam logic [CNT_W-1:0]   V_MAX_C   = CNT_W'(V_MAX);
   localparam logic [EW-1:0]      H_MIN_E   = EW'(H_MIN);
   localparam logic [EW-1:0]      H_MAX_E   = EW'(H_MAX);
   localparam logic [EW-1:0]      V_MIN_E   = EW'(V_MIN);
   localparam logic [EW-1:0]      V_MAX_E   = EW'(V_MAX);
   localparam logic [EW-1:0]      PAD_E     = EW'(PAD);
   localparam logic [EW-1:0]      BOX_T_E   = EW'(BOX_T);
   localparam logic [COUNT_W-1:0] MIN_PIX_C = COUNT_W'(MIN_PIX);
   localparam logic [COUNT_W-1:0] CNT_SAT   = '1;
   localparam logic [7:0]         MISS_LAST = 8'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_TRACK   = 2'd1,
      ST_COAST   = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_e             state_q,     state_d;
   logic [7:0]         miss_q,      miss_d;
   logic [CNT_W-1:0]   min_h_q,     min_h_d;
   logic [CNT_W-1:0]   max_h_q,     max_h_d;
   logic [CNT_W-1:0]   min_v_q,     min_v_d;
   logic [CNT_W-1:0]   max_v_q,     max_v_d;
   logic [COUNT_W-1:0] cnt_q,       cnt_d;
   logic [CNT_W-1:0]   bbox_x0_q,   bbox_x0_d;
   logic [CNT_W-1:0]   bbox_x1_q,   bbox_x1_d;
   logic [CNT_W-1:0]   bbox_y0_q,   bbox_y0_d;
   logic [CNT_W-1:0]   bbox_y1_q,   bbox_y1_d;
   logic [COUNT_W-1:0] pix_count_q, pix_count_d;
   logic               box_on_q,    box_on_d;

   // ---------------------------------------------------------------------------
   // Pixel qualification
   // ---------------------------------------------------------------------------
   logic in_win;
   logic fg_hit;

   assign in_win = pix_valid &&
                   (hcnt >= H_MIN_C) && (hcnt <= H_MAX_C) &&
                   (vcnt >= V_MIN_C) && (vcnt <= V_MAX_C);
   assign fg_hit = in_win && fg;

   // ---------------------------------------------------------------------------
   // Accumulators. A pixel arriving together with frame_sync seeds the next
   // frame rather than extending the one being closed.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned; otherwise a latch is inferred.
      min_h_d = min_h_q;
      max_h_d = max_h_q;
      min_v_d = min_v_q;
      max_v_d = max_v_q;
      cnt_d   = cnt_q;

      if (frame_sync) begin
         if (fg_hit) begin
            min_h_d = hcnt;
            max_h_d = hcnt;
            min_v_d = vcnt;
            max_v_d = vcnt;
            cnt_d   = COUNT_W'(1);
         end else begin
            min_h_d = '1;
            max_h_d = '0;
            min_v_d = '1;
            max_v_d = '0;
            cnt_d   = '0;
         end
      end else if (fg_hit) begin
         if (hcnt < min_h_q) min_h_d = hcnt;
         if (hcnt > max_h_q) max_h_d = hcnt;
         if (vcnt < min_v_q) min_v_d = vcnt;
         if (vcnt > max_v_q) max_v_d = vcnt;
         if (cnt_q != CNT_SAT) cnt_d = cnt_q + COUNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Padded, clamped box candidate from the current accumulators
   // ---------------------------------------------------------------------------
   logic [EW-1:0]    x0_ext, x1_ext, y0_ext, y1_ext;
   logic [CNT_W-1:0] x0_new, x1_new, y0_new, y1_new;
   logic             detect;

   assign x0_ext = {1'b0, min_h_q} - PAD_E;
   assign x1_ext = {1'b0, max_h_q} + PAD_E;
   assign y0_ext = {1'b0, min_v_q} - PAD_E;
   assign y1_ext = {1'b0, max_v_q} + PAD_E;

   // The top bit of a difference flags a borrow; that case is clamped too.
   assign x0_new = (x0_ext[CNT_W] || (x0_ext < H_MIN_E)) ? H_MIN_C : x0_ext[CNT_W-1:0];
   assign x1_new = (x1_ext > H_MAX_E)                    ? H_MAX_C : x1_ext[CNT_W-1:0];
   assign y0_new = (y0_ext[CNT_W] || (y0_ext < V_MIN_E)) ? V_MIN_C : y0_ext[CNT_W-1:0];
   assign y1_new = (y1_ext > V_MAX_E)                    ? V_MAX_C : y1_ext[CNT_W-1:0];

   assign detect = (cnt_q >= MIN_PIX_C);

   // ---------------------------------------------------------------------------
   // Tracking state machine and commit
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      miss_d      = miss_q;
      bbox_x0_d   = bbox_x0_q;
      bbox_x1_d   = bbox_x1_q;
      bbox_y0_d   = bbox_y0_q;
      bbox_y1_d   = bbox_y1_q;
      pix_count_d = pix_count_q;

      if (frame_sync) begin
         pix_count_d = cnt_q;
         if (detect) begin
            state_d   = ST_TRACK;
            miss_d    = '0;
            bbox_x0_d = x0_new;
            bbox_x1_d = x1_new;
            bbox_y0_d = y0_new;
            bbox_y1_d = y1_new;
         end else if ((state_q != ST_ACQUIRE) && (miss_q < MISS_LAST)) begin
            state_d = ST_COAST;
            miss_d  = miss_q + 8'd1;
         end else begin
            // Box registers keep the stale box; only visibility drops.
            state_d = ST_ACQUIRE;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Overlay ring. Edge tests are done as h + T > x1 rather than h > x1 - T so
   // a box narrower than the ring never needs a subtraction that could borrow.
   // ---------------------------------------------------------------------------
   logic          inside_box;
   logic          near_edge;
   logic [EW-1:0] h_ext, v_ext;

   assign h_ext = {1'b0, hcnt};
   assign v_ext = {1'b0, vcnt};

   assign inside_box = (hcnt >= bbox_x0_q) && (hcnt <= bbox_x1_q) &&
                       (vcnt >= bbox_y0_q) && (vcnt <= bbox_y1_q);

   assign near_edge  = (h_ext < ({1'b0, bbox_x0_q} + BOX_T_E)) ||
                       ((h_ext + BOX_T_E) > {1'b0, bbox_x1_q}) ||
                       (v_ext < ({1'b0, bbox_y0_q} + BOX_T_E)) ||
                       ((v_ext + BOX_T_E) > {1'b0, bbox_y1_q});

   always_comb begin
      box_on_d = (state_q != ST_ACQUIRE) && pix_valid && inside_box && near_edge;
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   // NOTE: the accumulators are plain flops (not a RAM) and are reset to the
   // cleared state so a reset mid-frame discards the partial frame.
   always_ff @(posedge clk_24m or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACQUIRE;
         miss_q      <= '0;
         min_h_q     <= '1;
         max_h_q     <= '0;
         min_v_q     <= '1;
         max_v_q     <= '0;
         cnt_q       <= '0;
         bbox_x0_q   <= H_MIN_C;
         bbox_x1_q   <= H_MAX_C;
         bbox_y0_q   <= V_MIN_C;
         bbox_y1_q   <= V_MAX_C;
         pix_count_q <= '0;
         box_on_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         miss_q      <= miss_d;
         min_h_q     <= min_h_d;
         max_h_q     <= max_h_d;
         min_v_q     <= min_v_d;
         max_v_q     <= max_v_d;
         cnt_q       <= cnt_d;
         bbox_x0_q   <= bbox_x0_d;
         bbox_x1_q   <= bbox_x1_d;
         bbox_y0_q   <= bbox_y0_d;
         bbox_y1_q   <= bbox_y1_d;
         pix_count_q <= pix_count_d;
         box_on_q    <= box_on_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign box_on     = box_on_q;
   assign bbox_valid = (state_q != ST_ACQUIRE);
   assign coasting   = (state_q == ST_COAST);
   assign bbox_x0    = bbox_x0_q;
   assign bbox_x1    = bbox_x1_q;
   assign bbox_y0    = bbox_y0_q;
   assign bbox_y1    = bbox_y1_q;
   assign pix_count  = pix_count_q;

endmodule

// File: tb/tb_target_bbox_tracker.sv
// -----------------------------------------------------------------------------
// tb_target_bbox_tracker
//
// Bench for target_bbox_tracker. A frame-level reference model (integer
// min/max/count accumulation, commit rules and ring test) tracks the expected
// outputs; a negedge process compares every output each cycle, and the
// directed sections add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_target_bbox_tracker;

   localparam int CNT_W       = 11;
   localparam int H_MIN       = 154;
   localparam int H_MAX       = 784;
   localparam int V_MIN       = 35;
   localparam int V_MAX       = 515;
   localparam int PAD         = 4;
   localparam int BOX_T       = 3;
   localparam int MIN_PIX     = 16;
   localparam int HOLD_FRAMES = 8;
   localparam int COUNT_W     = 16;

   localparam int M_ACQ   = 0;
   localparam int M_TRACK = 1;
   localparam int M_COAST = 2;

   logic               clk_24m;
   logic               rst_n;
   logic               pix_valid;
   logic               fg;
   logic [CNT_W-1:0]   hcnt;
   logic [CNT_W-1:0]   vcnt;
   logic               frame_sync;
   logic               box_on;
   logic               bbox_valid;
   logic [CNT_W-1:0]   bbox_x0;
   logic [CNT_W-1:0]   bbox_x1;
   logic [CNT_W-1:0]   bbox_y0;
   logic [CNT_W-1:0]   bbox_y1;
   logic [COUNT_W-1:0] pix_count;
   logic               coasting;

   target_bbox_tracker #(
      .CNT_W(CNT_W), .H_MIN(H_MIN), .H_MAX(H_MAX), .V_MIN(V_MIN), .V_MAX(V_MAX),
      .PAD(PAD), .BOX_T(BOX_T), .MIN_PIX(MIN_PIX), .HOLD_FRAMES(HOLD_FRAMES),
      .COUNT_W(COUNT_W)
   ) dut (
      .clk_24m   (clk_24m),
      .rst_n     (rst_n),
      .pix_valid (pix_valid),
      .fg        (fg),
      .hcnt      (hcnt),
      .vcnt      (vcnt),
      .frame_sync(frame_sync),
      .box_on    (box_on),
      .bbox_valid(bbox_valid),
      .bbox_x0   (bbox_x0),
      .bbox_x1   (bbox_x1),
      .bbox_y0   (bbox_y0),
      .bbox_y1   (bbox_y1),
      .pix_count (pix_count),
      .coasting  (coasting)
   );

   initial clk_24m = 1'b0;
   always #5 clk_24m = ~clk_24m;

   int checks;
   int failures;
   bit chk_en;

   // Reference model state
   int m_mode, m_miss;
   int m_x0, m_x1, m_y0, m_y1, m_pc, m_box_on;
   int a_cnt, a_mnh, a_mxh, a_mnv, a_mxv;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rnd(input int lo, input int hi);
      return int'($urandom_range(hi, lo));
   endfunction

   function automatic void acc_clear();
      a_cnt = 0;
      a_mnh = (1 << CNT_W) - 1;
      a_mxh = 0;
      a_mnv = (1 << CNT_W) - 1;
      a_mxv = 0;
   endfunction

   function automatic void acc_add(input int h, input int v);
      if (h < a_mnh) a_mnh = h;
      if (h > a_mxh) a_mxh = h;
      if (v < a_mnv) a_mnv = v;
      if (v > a_mxv) a_mxv = v;
      if (a_cnt < (1 << COUNT_W) - 1) a_cnt++;
   endfunction

   function automatic void model_reset();
      m_mode = M_ACQ;  m_miss = 0;
      m_x0 = H_MIN;    m_x1 = H_MAX;
      m_y0 = V_MIN;    m_y1 = V_MAX;
      m_pc = 0;        m_box_on = 0;
      acc_clear();
   endfunction

   // Advances the model by one clock edge using the inputs present at the edge.
   task automatic model_clock();
      int  h, v, nb;
      bit  inwin;
      h = int'(hcnt);
      v = int'(vcnt);
      inwin = pix_valid && h >= H_MIN && h <= H_MAX && v >= V_MIN && v <= V_MAX;
      nb = (m_mode != M_ACQ && pix_valid &&
            h >= m_x0 && h <= m_x1 && v >= m_y0 && v <= m_y1 &&
            (h < m_x0 + BOX_T || h > m_x1 - BOX_T ||
             v < m_y0 + BOX_T || v > m_y1 - BOX_T)) ? 1 : 0;
      if (frame_sync) begin
         m_pc = a_cnt;
         if (a_cnt >= MIN_PIX) begin
            m_x0 = (a_mnh - PAD < H_MIN) ? H_MIN : a_mnh - PAD;
            m_x1 = (a_mxh + PAD > H_MAX) ? H_MAX : a_mxh + PAD;
            m_y0 = (a_mnv - PAD < V_MIN) ? V_MIN : a_mnv - PAD;
            m_y1 = (a_mxv + PAD > V_MAX) ? V_MAX : a_mxv + PAD;
            m_mode = M_TRACK;
            m_miss = 0;
         end else if (m_mode != M_ACQ && m_miss < HOLD_FRAMES - 1) begin
            m_mode = M_COAST;
            m_miss++;
         end else begin
            m_mode = M_ACQ;
         end
         acc_clear();
         if (inwin && fg) acc_add(h, v);
      end else if (inwin && fg) begin
         acc_add(h, v);
      end
      m_box_on = nb;
   endtask

   // One clock: present inputs, let the edge happen, advance the model.
   task automatic step(input bit pv, input bit f, input int h, input int v, input bit fs);
      pix_valid  = pv;
      fg         = f;
      hcnt       = CNT_W'(h);
      vcnt       = CNT_W'(v);
      frame_sync = fs;
      @(posedge clk_24m);
      model_clock();
      #1;
   endtask

   task automatic send_patch(input int h0, input int h1, input int v0, input int v1);
      for (int v = v0; v <= v1; v++)
         for (int h = h0; h <= h1; h++)
            step(1'b1, 1'b1, h, v, 1'b0);
   endtask

   task automatic close_frame();
      step(1'b0, 1'b0, 0, 0, 1'b1);
   endtask

   task automatic check_box(input string tag, input int x0, input int x1, input int y0, input int y1);
      check({tag, "_x0"}, int'(bbox_x0), x0);
      check({tag, "_x1"}, int'(bbox_x1), x1);
      check({tag, "_y0"}, int'(bbox_y0), y0);
      check({tag, "_y1"}, int'(bbox_y1), y1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_box_on"},   int'(box_on),     0);
      check({tag, "_valid"},    int'(bbox_valid), 0);
      check({tag, "_coasting"}, int'(coasting),   0);
      check({tag, "_pc"},       int'(pix_count),  0);
      check_box(tag, H_MIN, H_MAX, V_MIN, V_MAX);
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk_24m) begin
      if (chk_en) begin
         check("box_on",     int'(box_on),     m_box_on);
         check("bbox_valid", int'(bbox_valid), (m_mode != M_ACQ) ? 1 : 0);
         check("coasting",   int'(coasting),   (m_mode == M_COAST) ? 1 : 0);
         check("bbox_x0",    int'(bbox_x0),    m_x0);
         check("bbox_x1",    int'(bbox_x1),    m_x1);
         check("bbox_y0",    int'(bbox_y0),    m_y0);
         check("bbox_y1",    int'(bbox_y1),    m_y1);
         check("pix_count",  int'(pix_count),  m_pc);
      end
   end

   initial begin
      int cx, cy, s, n, r, exp_on;
      checks     = 0;
      failures   = 0;
      chk_en     = 1'b0;
      rst_n      = 1'b0;
      pix_valid  = 1'b0;
      fg         = 1'b0;
      hcnt       = '0;
      vcnt       = '0;
      frame_sync = 1'b0;
      model_reset();

      #12;
      check_reset_outputs("reset");
      @(negedge clk_24m);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Basic detection: 20x20 patch
      send_patch(300, 319, 200, 219);
      close_frame();
      check_box("basic", 296, 323, 196, 223);
      check("basic_pc",    int'(pix_count),  400);
      check("basic_valid", int'(bbox_valid), 1);
      check("basic_coast", int'(coasting),   0);

      // Ring rendering: top band row and a middle row
      for (int h = 290; h <= 330; h++) begin
         step(1'b1, 1'b0, h, 197, 1'b0);
         check("ring_v197", int'(box_on), (h >= 296 && h <= 323) ? 1 : 0);
      end
      for (int h = 290; h <= 330; h++) begin
         step(1'b1, 1'b0, h, 210, 1'b0);
         exp_on = ((h >= 296 && h <= 298) || (h >= 321 && h <= 323)) ? 1 : 0;
         check("ring_v210", int'(box_on), exp_on);
      end

      // Loss and coast: 8 frames of 10 pixels each
      for (int k = 1; k <= 8; k++) begin
         for (int p = 0; p < 10; p++)
            step(1'b1, 1'b1, rnd(H_MIN, H_MAX), rnd(V_MIN, V_MAX), 1'b0);
         close_frame();
         if (k < 8) begin
            check("coast_flag", int'(coasting), 1);
            check_box("coast", 296, 323, 196, 223);
         end else begin
            check("lost_valid", int'(bbox_valid), 0);
            check("lost_coast", int'(coasting),   0);
         end
      end
      for (int h = 290; h <= 330; h++) begin
         step(1'b1, 1'b0, h, 197, 1'b0);
         check("lost_box_on", int'(box_on), 0);
      end
      send_patch(400, 403, 300, 303);
      close_frame();
      check("reacq_valid", int'(bbox_valid), 1);
      check("reacq_coast", int'(coasting),   0);
      check("reacq_pc",    int'(pix_count),  16);
      check_box("reacq", 396, 407, 296, 307);
      close_frame();
      check("reacq_miss1", int'(coasting), 1);

      // Edge clamping, both corners
      send_patch(154, 160, 35, 40);
      close_frame();
      check_box("clamp_lo", 154, 164, 35, 44);
      check("clamp_lo_pc", int'(pix_count), 42);
      send_patch(780, 784, 510, 515);
      close_frame();
      check_box("clamp_hi", 776, 784, 506, 515);

      // Same-cycle pixel and frame_sync
      send_patch(450, 454, 100, 103);
      step(1'b1, 1'b1, 500, 300, 1'b1);
      check("same_pc", int'(pix_count), 20);
      check_box("same", 446, 458, 96, 107);
      close_frame();
      check("same_pc_next", int'(pix_count), 1);
      check("same_coast",   int'(coasting),  1);

      // Back-to-back frame_sync pulses
      close_frame();
      close_frame();
      close_frame();

      // Randomized frames
      for (int f = 0; f < 80; f++) begin
         cx = rnd(H_MIN - 10, H_MAX + 10);
         cy = rnd(V_MIN, V_MAX + 10);
         s  = rnd(0, 30);
         n  = rnd(0, 50);
         for (int p = 0; p < n; p++) begin
            r = rnd(0, 9);
            if (r < 6)
               step(1'b1, 1'b1, rnd(cx - s, cx + s), rnd(cy - s, cy + s), 1'b0);
            else if (r < 8)
               step(1'b1, 1'b0, rnd(m_x0 - 2, m_x1 + 2), rnd(m_y0 - 2, m_y1 + 2), 1'b0);
            else
               step((r == 8) ? 1'b0 : 1'b1, 1'b1, rnd(140, 800), rnd(25, 525), 1'b0);
         end
         close_frame();
         if (rnd(0, 4) == 0)
            step(1'b1, 1'b1, rnd(H_MIN, H_MAX), rnd(V_MIN, V_MAX), 1'b1);
      end

      // Asynchronous reset mid-frame while tracking
      send_patch(300, 319, 200, 219);
      close_frame();
      check("pre_rst_valid", int'(bbox_valid), 1);
      send_patch(600, 610, 400, 401);
      chk_en     = 1'b0;
      pix_valid  = 1'b0;
      fg         = 1'b0;
      frame_sync = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(posedge clk_24m);
      #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      send_patch(500, 505, 250, 252);
      close_frame();
      check("post_rst_pc", int'(pix_count), 18);
      check_box("post_rst", 496, 509, 246, 256);

      step(1'b0, 1'b0, 0, 0, 1'b0);
      step(1'b0, 1'b0, 0, 0, 1'b0);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
